// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-bundle definitions for the pipelined ALU.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b0111;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1001;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Bit positions inside the registered flag bundle
    localparam int unsigned FLG_ZERO  = 0;
    localparam int unsigned FLG_OVF   = 1;
    localparam int unsigned FLG_CARRY = 2;
    localparam int unsigned FLG_NEG   = 3;
    localparam int unsigned FLG_ILL   = 4;
    localparam int unsigned FLAG_W    = 5;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle between register-read, the ALU and writeback.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic              out_zero;
    logic              out_overflow;
    logic              out_carry;
    logic              out_negative;
    logic              out_illegal;
    logic              busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_overflow,
               out_carry, out_negative, out_illegal, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_overflow,
               out_carry, out_negative, out_illegal, busy
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Present only when ALU_PIPE_MUL_EN is defined.
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done_c,
    output logic [2*WIDTH-1:0]   o_prod_c
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W   = SHAMT_W + 1;
    localparam int unsigned PROD_W  = 2 * WIDTH;

    logic [CNT_W-1:0]  r_cnt;
    logic [PROD_W-1:0] r_prod;
    logic [PROD_W-1:0] r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PROD_W-1:0] w_prod_next;

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    // Last iteration is presented combinationally so the top registers it directly
    assign o_done_c = (r_cnt == CNT_W'(1));
    assign o_prod_c = w_prod_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_prod   <= '0;
            r_mcand  <= PROD_W'(i_a);
            r_mplier <= i_b;
        end else if (r_cnt != '0) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; absorbs writeback stalls.
// Define ALU_PIPE_MUL_EN to build the iterative multiplier (opcode 1010).
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);
    import alu_pkg::*;

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic                     w_idle;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_load_single;
    logic                     w_mul_fin;
    logic [WIDTH-1:0]         w_mul_res;
    logic [FLAG_W-1:0]        w_mul_flags;

    logic [WIDTH-1:0]         w_res;
    logic [FLAG_W-1:0]        w_flags;
    logic [WIDTH:0]           w_sum;
    logic [WIDTH:0]           w_diff;
    logic [SHAMT_W-1:0]       w_shamt;
    logic signed [WIDTH-1:0]  w_sra;
    logic                     w_ovf;
    logic                     w_carry;
    logic                     w_ill;

    logic                     r_valid;
    logic [WIDTH-1:0]         r_result;
    logic [FLAG_W-1:0]        r_flags;

    assign w_in_ready = w_idle && (!r_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

`ifdef ALU_PIPE_MUL_EN
    state_t              r_state;
    logic                w_is_mul;
    logic                w_mul_start;
    logic                w_mul_done;
    logic [2*WIDTH-1:0]  w_mul_prod;

    assign w_is_mul      = (bus.in_op == OP_MUL);
    assign w_mul_start   = w_accept && w_is_mul;
    assign w_idle        = (r_state == ST_IDLE);
    assign w_load_single = w_accept && !w_is_mul;
    assign w_mul_fin     = (r_state == ST_MUL) && w_mul_done;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_mul_start),
        .i_a      (bus.in_a),
        .i_b      (bus.in_b),
        .o_done_c (w_mul_done),
        .o_prod_c (w_mul_prod)
    );

    assign w_mul_res = w_mul_prod[WIDTH-1:0];

    always_comb begin
        w_mul_flags            = '0;
        w_mul_flags[FLG_ZERO]  = (w_mul_res == '0);
        w_mul_flags[FLG_OVF]   = |w_mul_prod[2*WIDTH-1:WIDTH];
        w_mul_flags[FLG_NEG]   = w_mul_res[WIDTH-1];
    end

    // IDLE -> MUL on multiply accept; back to IDLE with the final iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_mul_start) r_state <= ST_MUL;
                ST_MUL:  if (w_mul_done)  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != ST_IDLE);
`else
    assign w_idle        = 1'b1;
    assign w_load_single = w_accept;
    assign w_mul_fin     = 1'b0;
    assign w_mul_res     = '0;
    assign w_mul_flags   = '0;
    assign bus.busy      = 1'b0;
`endif

    assign w_sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign w_diff  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    assign w_shamt = bus.in_b[SHAMT_W-1:0];
    assign w_sra   = $signed(bus.in_a) >>> w_shamt;

    // Single-cycle operation decode
    always_comb begin
        w_res   = '0;
        w_ovf   = 1'b0;
        w_carry = 1'b0;
        w_ill   = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_AND:  w_res = bus.in_a & bus.in_b;
            OP_OR:   w_res = bus.in_a | bus.in_b;
            OP_XOR:  w_res = bus.in_a ^ bus.in_b;
            OP_SLT:  w_res = WIDTH'($signed(bus.in_a) < $signed(bus.in_b));
            OP_SLTU: w_res = WIDTH'(bus.in_a < bus.in_b);
            OP_SLL:  w_res = bus.in_a << w_shamt;
            OP_SRL:  w_res = bus.in_a >> w_shamt;
            OP_SRA:  w_res = w_sra;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  w_ill = 1'b0;
`endif
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_flags            = '0;
        w_flags[FLG_ZERO]  = (w_res == '0);
        w_flags[FLG_OVF]   = w_ovf;
        w_flags[FLG_CARRY] = w_carry;
        w_flags[FLG_NEG]   = w_res[WIDTH-1];
        w_flags[FLG_ILL]   = w_ill;
    end

    // Output registers hold while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_load_single) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_flags  <= w_flags;
        end else if (w_mul_fin) begin
            r_valid  <= 1'b1;
            r_result <= w_mul_res;
            r_flags  <= w_mul_flags;
        end else if (r_valid && bus.out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid;
    assign bus.out_result   = r_result;
    assign bus.out_zero     = r_flags[FLG_ZERO];
    assign bus.out_overflow = r_flags[FLG_OVF];
    assign bus.out_carry    = r_flags[FLG_CARRY];
    assign bus.out_negative = r_flags[FLG_NEG];
    assign bus.out_illegal  = r_flags[FLG_ILL];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16); follows ALU_PIPE_MUL_EN if defined.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic z, v, c, n, il;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk(input logic [W-1:0] r, input logic z, v, c, n, il);
        exp_t e;
        e.res = r; e.z = z; e.v = v; e.c = c; e.n = n; e.il = il;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every transfer on the output side is compared with the queue head
    exp_t act_m;
    exp_t exp_m;
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            act_m = {bus.out_result, bus.out_zero, bus.out_overflow,
                     bus.out_carry, bus.out_negative, bus.out_illegal};
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %h expected none", act_m);
            end else begin
                exp_m = q.pop_front();
                chk("result", 32'(act_m), 32'(exp_m));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                q.push_back(e);
            end
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: op %h got no in_ready expected in_ready=1", op);
        end
    endtask

    function automatic logic [23:0] snap();
        return {bus.out_valid, bus.out_result, bus.out_zero, bus.out_overflow,
                bus.out_carry, bus.out_negative, bus.out_illegal, bus.busy, bus.in_ready};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        #1;
        chk("reset_state", 32'(snap()), 32'h000001);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency-1 ADD with signed overflow
        send(OP_ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 1, 0, 1, 0));
        @(negedge clk);
        chk("add_latency", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;

        // Back-to-back burst of single-cycle ops
        send(OP_SUB,  16'h0003, 16'h0005, mk(16'hFFFE, 0, 0, 1, 1, 0));
        send(OP_SLT,  16'h8000, 16'h0001, mk(16'h0001, 0, 0, 0, 0, 0));
        send(OP_SLTU, 16'h8000, 16'h0001, mk(16'h0000, 1, 0, 0, 0, 0));
        send(OP_SRA,  16'h8000, 16'h0013, mk(16'hF000, 0, 0, 0, 1, 0));
        send(OP_SLL,  16'h0001, 16'h000F, mk(16'h8000, 0, 0, 0, 1, 0));
        send(4'hF,    16'h1234, 16'h5678, mk(16'h0000, 1, 0, 0, 0, 1));
        send(OP_AND,  16'hF0F0, 16'hFF00, mk(16'hF000, 0, 0, 0, 1, 0));
        send(OP_OR,   16'h0F00, 16'h00F0, mk(16'h0FF0, 0, 0, 0, 0, 0));
        send(OP_XOR,  16'hFFFF, 16'hFFFF, mk(16'h0000, 1, 0, 0, 0, 0));
        send(OP_SRL,  16'h8000, 16'h0004, mk(16'h0800, 0, 0, 0, 0, 0));
        send(OP_ADD,  16'hFFFF, 16'h0001, mk(16'h0000, 1, 0, 1, 0, 0));
        send(OP_SUB,  16'h8000, 16'h0001, mk(16'h7FFF, 0, 1, 0, 0, 0));
        send(OP_SLT,  16'h0001, 16'h8000, mk(16'h0000, 1, 0, 0, 0, 0));
        repeat (2) @(posedge clk); #1;

`ifdef ALU_PIPE_MUL_EN
        send(OP_MUL, 16'h0100, 16'h0100, mk(16'h0000, 1, 1, 0, 0, 0));
        bus.in_a = 16'hFFFF;
        bus.in_b = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("mul_busy", 32'({bus.busy, bus.out_valid, bus.in_ready}), 32'b100);
        end
        @(negedge clk);
        chk("mul_done", 32'({bus.busy, bus.out_valid}), 32'b01);
`else
        send(OP_MUL, 16'h0100, 16'h0100, mk(16'h0000, 1, 0, 0, 0, 1));
        @(negedge clk);
        chk("mul_illegal_latency", 32'({bus.busy, bus.out_valid}), 32'b01);
`endif
        @(posedge clk); #1;

        // Consumer stall: outputs hold and input side closes
        bus.out_ready = 1'b0;
        send(OP_OR, 16'h0F00, 16'h00F0, mk(16'h0FF0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold", 32'({bus.in_ready, bus.out_valid, bus.out_result, bus.out_zero,
                             bus.out_overflow, bus.out_carry, bus.out_negative, bus.out_illegal}),
                32'({1'b0, 1'b1, 16'h0FF0, 5'b00000}));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(OP_XOR, 16'h00FF, 16'hFFFF, mk(16'hFF00, 0, 0, 0, 1, 0));
        @(negedge clk);
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset with work in flight
`ifdef ALU_PIPE_MUL_EN
        send(OP_MUL, 16'h0003, 16'h0005, mk(16'h000F, 0, 0, 0, 0, 0));
        repeat (5) @(negedge clk);
        chk("mid_mul_busy", 32'(bus.busy), 32'd1);
`else
        bus.out_ready = 1'b0;
        send(OP_ADD, 16'h0001, 16'h0001, mk(16'h0002, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        chk("reset_mid_op", 32'(snap()), 32'h000001);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(OP_ADD, 16'h0002, 16'h0003, mk(16'h0005, 0, 0, 0, 0, 0));

        repeat (5) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
